// File: rtl/ring_counter_pkg.sv
// Shared types and legality helpers for the ring/Johnson counter family.
// Helpers work on a zero-extended MAX_W vector so any WIDTH up to MAX_W can use them.
package ring_counter_pkg;

   typedef enum logic [1:0] {
      MODE_RING    = 2'b00,
      MODE_JOHNSON = 2'b01,
      MODE_HOLD    = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_t;

   localparam int unsigned    MAX_W       = 64;
   localparam logic [MAX_W-1:0] RESET_STATE = 64'd1;

   function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
      if (w >= MAX_W) begin
         return {MAX_W{1'b1}};
      end else begin
         return (RESET_STATE << w) - RESET_STATE;
      end
   endfunction

   function automatic logic is_onehot(input logic [MAX_W-1:0] v, input int unsigned w);
      return $onehot(v & width_mask(w));
   endfunction

   // A legal Johnson code is a run of ones anchored at bit 0, or its complement.
   function automatic logic is_johnson(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] t;
      logic [MAX_W-1:0] n;
      t = v & width_mask(w);
      n = ~v & width_mask(w);
      return ((t & (t + RESET_STATE)) == {MAX_W{1'b0}}) ||
             ((n & (n + RESET_STATE)) == {MAX_W{1'b0}});
   endfunction

endpackage

// File: rtl/ring_counter_gen_prescaler.sv
// Programmable divider: emits a one-cycle tick on every (div+1)-th enabled cycle.
// The tick is combinational from the count so a lowered div takes effect at once.
module prescaler_tick #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   // Next-count and tick decode; clear wins over counting.
   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {PRESCALE_W{1'b0}};
      end else if (ena) begin
         if (cnt_q >= div) begin
            tick  = 1'b1;
            cnt_d = {PRESCALE_W{1'b0}};
         end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {PRESCALE_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ring_counter_gen.sv
// Ring/Johnson counter with direction, prescaler, parallel load and illegal-state recovery.
// All outputs come straight from flops.
module ring_counter_gen
   import ring_counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [1:0]            mode,
   input  logic                  dir,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   output logic [WIDTH-1:0]      q,
   output logic                  tick_out,
   output logic                  wrap,
   output logic                  illegal
);

   localparam logic [WIDTH-1:0] Q_RESET = WIDTH'(RESET_STATE);

   mode_t            mode_s;
   logic             run_s;
   logic             adv_s;
   logic             legal_s;
   logic [WIDTH-1:0] shifted_s;

   logic [WIDTH-1:0] q_q,       q_d;
   logic             tick_q,    tick_d;
   logic             wrap_q,    wrap_d;
   logic             illegal_q, illegal_d;

   assign mode_s = mode_t'(mode);
   assign run_s  = ena && ((mode_s == MODE_RING) || (mode_s == MODE_JOHNSON));

   prescaler_tick #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (run_s),
      .div  (div),
      .clr  (load),
      .tick (adv_s)
   );

   // Candidate shift and legality of the current state under the live mode.
   always_comb begin
      legal_s   = 1'b1;
      shifted_s = q_q;
      case (mode_s)
         MODE_RING: begin
            legal_s = is_onehot(MAX_W'(q_q), WIDTH);
            if (dir) begin
               shifted_s = {q_q[0], q_q[WIDTH-1:1]};
            end else begin
               shifted_s = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            end
         end
         MODE_JOHNSON: begin
            legal_s = is_johnson(MAX_W'(q_q), WIDTH);
            if (dir) begin
               shifted_s = {~q_q[0], q_q[WIDTH-1:1]};
            end else begin
               shifted_s = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            end
         end
         default: begin
            legal_s   = 1'b1;
            shifted_s = q_q;
         end
      endcase
   end

   // Next state: load beats advance; an illegal state is replaced by the reset code.
   always_comb begin
      q_d       = q_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;
      if (load) begin
         q_d = load_val;
      end else if (adv_s) begin
         if (legal_s) begin
            q_d = shifted_s;
         end else begin
            q_d = Q_RESET;
         end
         tick_d    = 1'b1;
         wrap_d    = (q_d == Q_RESET);
         illegal_d = !legal_s;
      end else begin
         q_d = q_q;
      end
   end

   // State and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q       <= Q_RESET;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign q        = q_q;
   assign tick_out = tick_q;
   assign wrap     = wrap_q;
   assign illegal  = illegal_q;

endmodule
